// File: rtl/snn_pkg.sv
// Shared definitions for the SNN Wishbone controller: register map, weight
// window bounds, FSM state encodings and control/status bit positions.
package snn_pkg;

  localparam logic [15:0] OFF_CTRL       = 16'h0000;
  localparam logic [15:0] OFF_STATUS     = 16'h0004;
  localparam logic [15:0] OFF_TIMESTEPS  = 16'h0008;
  localparam logic [15:0] OFF_STEP_COUNT = 16'h000C;
  localparam logic [15:0] OFF_SPK_IN     = 16'h0010;
  localparam logic [15:0] OFF_SPK_OUT    = 16'h0014;
  localparam logic [15:0] OFF_SPK_ANY    = 16'h0018;

  localparam logic [15:0] WGT_LO = 16'h1000;
  localparam logic [15:0] WGT_HI = 16'h1FFC;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;

  typedef enum logic [1:0] {
    B_IDLE,
    B_WGT,
    B_ACK
  } bus_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_STEP,
    R_WAIT
  } run_state_e;

  function automatic logic in_wgt_window(input logic [15:0] off);
    return (off >= WGT_LO) && (off <= WGT_HI);
  endfunction

endpackage

// File: rtl/snn_wb_ctrl_if.sv
// Wishbone classic slave bus bundle; signal suffixes are from the slave's view.
interface snn_wb_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/snn_run_ctrl.sv
// Inference run sequencer: issues one step pulse per timestep, collects the
// core's output spikes and reports completion with a single-cycle done pulse.
module snn_run_ctrl
  import snn_pkg::*;
#(
  parameter int NEURONS = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [15:0]        timesteps_i,
  input  logic               step_done_i,
  input  logic [NEURONS-1:0] spk_out_i,
  output logic               step_o,
  output logic               busy_o,
  output logic               start_acc_o,
  output logic               done_set_o,
  output logic [15:0]        step_cnt_o,
  output logic [NEURONS-1:0] spk_out_o,
  output logic [NEURONS-1:0] spk_any_o
);

  run_state_e         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [NEURONS-1:0] out_q, out_d;
  logic [NEURONS-1:0] any_q, any_d;
  logic [15:0]        cnt_inc;

  assign cnt_inc = cnt_q + 16'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= R_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      any_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      any_q   <= any_d;
    end
  end

  // Abort overrides everything, including a coincident start or step_done.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    any_d       = any_q;
    start_acc_o = 1'b0;
    done_set_o  = 1'b0;
    if (abort_i) begin
      state_d = R_IDLE;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (start_i) begin
            start_acc_o = 1'b1;
            cnt_d       = '0;
            any_d       = '0;
            if (timesteps_i == 16'd0) done_set_o = 1'b1;
            else                      state_d    = R_STEP;
          end
        end
        R_STEP: state_d = R_WAIT;
        R_WAIT: begin
          if (step_done_i) begin
            out_d = spk_out_i;
            any_d = any_q | spk_out_i;
            cnt_d = cnt_inc;
            if (cnt_inc == timesteps_i) begin
              done_set_o = 1'b1;
              state_d    = R_IDLE;
            end else begin
              state_d = R_STEP;
            end
          end
        end
        default: state_d = R_IDLE;
      endcase
    end
  end

  assign step_o     = (state_q == R_STEP);
  assign busy_o     = (state_q != R_IDLE);
  assign step_cnt_o = cnt_q;
  assign spk_out_o  = out_q;
  assign spk_any_o  = any_q;

endmodule

// File: rtl/snn_wb_ctrl.sv
// Wishbone slave for the SNN core: register file, weight-write forwarding
// with a ready handshake, and the run sequencer that drives the interrupt.
module snn_wb_ctrl
  import snn_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          INPUTS    = 32,
  parameter int          NEURONS   = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  snn_wb_ctrl_if.slave       wb,
  output logic               w_wr_o,
  output logic [9:0]         w_addr_o,
  output logic [31:0]        w_data_o,
  input  logic               w_ready_i,
  output logic [INPUTS-1:0]  spk_in_o,
  output logic               step_o,
  input  logic               step_done_i,
  input  logic [NEURONS-1:0] spk_out_i,
  output logic               irq_o
);

  bus_state_e        bus_q, bus_d;
  logic [9:0]        w_addr_q, w_addr_d;
  logic [31:0]       w_data_q, w_data_d;
  logic              irq_en_q, irq_en_d;
  logic              done_q, done_d;
  logic [15:0]       ts_q, ts_d;
  logic [INPUTS-1:0] spk_in_q, spk_in_d;

  logic [15:0]        off;
  logic               hit, req, wgt_full, wgt_go;
  logic               acc_we, wr_ctrl, wr_status, wr_ts, wr_spk;
  logic               start_p, abort_p;
  logic               busy, start_acc, done_set;
  logic [15:0]        step_cnt;
  logic [NEURONS-1:0] spk_out, spk_any;
  logic [31:0]        rdata;

  assign off      = wb.wbs_adr_i[15:0];
  assign hit      = (wb.wbs_adr_i[31:16] == BASE_ADDR[31:16]);
  assign req      = wb.wbs_cyc_i & wb.wbs_stb_i & hit & (bus_q != B_ACK);
  assign wgt_full = wb.wbs_we_i & in_wgt_window(off) & (wb.wbs_sel_i == 4'hF);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bus_q    <= B_IDLE;
      w_addr_q <= '0;
      w_data_q <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ts_q     <= '0;
      spk_in_q <= '0;
    end else begin
      bus_q    <= bus_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      ts_q     <= ts_d;
      spk_in_q <= spk_in_d;
    end
  end

  // Partial-lane weight writes take the plain ack path and are dropped there.
  always_comb begin
    bus_d = bus_q;
    case (bus_q)
      B_IDLE:  if (req) bus_d = wgt_full ? B_WGT : B_ACK;
      B_WGT:   if (w_ready_i) bus_d = B_ACK;
      B_ACK:   bus_d = B_IDLE;
      default: bus_d = B_IDLE;
    endcase
  end

  assign wgt_go    = (bus_q == B_IDLE) && (bus_d == B_WGT);
  assign acc_we    = (bus_q == B_ACK) && wb.wbs_we_i;
  assign wr_ctrl   = acc_we && (off == OFF_CTRL);
  assign wr_status = acc_we && (off == OFF_STATUS);
  assign wr_ts     = acc_we && (off == OFF_TIMESTEPS);
  assign wr_spk    = acc_we && (off == OFF_SPK_IN);
  assign start_p   = wr_ctrl && wb.wbs_dat_i[CTRL_START];
  assign abort_p   = wr_ctrl && wb.wbs_dat_i[CTRL_ABORT];

  always_comb begin
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    irq_en_d = irq_en_q;
    ts_d     = ts_q;
    spk_in_d = spk_in_q;
    done_d   = done_q;
    if (wgt_go) begin
      w_addr_d = wb.wbs_adr_i[11:2];
      w_data_d = wb.wbs_dat_i;
    end
    if (wr_ctrl) irq_en_d = wb.wbs_dat_i[CTRL_IRQ_EN];
    if (wr_ts) begin
      for (int b = 0; b < 2; b++)
        if (wb.wbs_sel_i[b]) ts_d[8*b +: 8] = wb.wbs_dat_i[8*b +: 8];
    end
    if (wr_spk) begin
      for (int i = 0; i < INPUTS; i++)
        if (wb.wbs_sel_i[i/8]) spk_in_d[i] = wb.wbs_dat_i[i];
    end
    // A completion in the same cycle as a clear must not be lost.
    if (done_set)
      done_d = 1'b1;
    else if (start_acc || (wr_status && wb.wbs_dat_i[STAT_DONE]))
      done_d = 1'b0;
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:       rdata[CTRL_IRQ_EN] = irq_en_q;
      OFF_STATUS: begin
        rdata[STAT_BUSY] = busy;
        rdata[STAT_DONE] = done_q;
      end
      OFF_TIMESTEPS:  rdata = 32'(ts_q);
      OFF_STEP_COUNT: rdata = 32'(step_cnt);
      OFF_SPK_IN:     rdata = 32'(spk_in_q);
      OFF_SPK_OUT:    rdata = 32'(spk_out);
      OFF_SPK_ANY:    rdata = 32'(spk_any);
      default:        rdata = '0;
    endcase
  end

  snn_run_ctrl #(
    .NEURONS(NEURONS)
  ) u_run (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .start_i     (start_p),
    .abort_i     (abort_p),
    .timesteps_i (ts_q),
    .step_done_i (step_done_i),
    .spk_out_i   (spk_out_i),
    .step_o      (step_o),
    .busy_o      (busy),
    .start_acc_o (start_acc),
    .done_set_o  (done_set),
    .step_cnt_o  (step_cnt),
    .spk_out_o   (spk_out),
    .spk_any_o   (spk_any)
  );

  assign wb.wbs_ack_o = (bus_q == B_ACK);
  assign wb.wbs_dat_o = ((bus_q == B_ACK) && !wb.wbs_we_i) ? rdata : '0;
  assign w_wr_o       = (bus_q == B_WGT);
  assign w_addr_o     = w_addr_q;
  assign w_data_o     = w_data_q;
  assign spk_in_o     = spk_in_q;
  assign irq_o        = done_q & irq_en_q;

endmodule

// File: doc/snn_wb_ctrl.md
# snn_wb_ctrl

Wishbone slave and run controller between the Caravel management bus and the `snn` core. Decodes the user-area Wishbone window, exposes control and status registers, forwards weight-memory writes to the core through a ready handshake, and sequences an inference run of N timesteps. It drives the run-complete interrupt.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h3000_0000: window base; a hit is `wbs_adr_i[31:16] == BASE_ADDR[31:16]`.
- `INPUTS`, default 32: input spike vector width, at most 32.
- `NEURONS`, default 16: output spike vector width, at most 32.

Ports:
- `wb_clk_i`  in  1  the only clock.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic cycle, strobe and write enable.
- `wbs_sel_i`  in  4  byte lanes.
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  address and write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data, valid only with ack; 0 otherwise.
- `w_wr_o`  out  1  weight write request.
- `w_addr_o`  out  10  weight word address, equal to `adr[11:2]`.
- `w_data_o`  out  32  weight data.
- `w_ready_i`  in  1  core accepts the weight write.
- `spk_in_o`  out  INPUTS  input spike vector to the core.
- `step_o`  out  1  one-cycle timestep pulse.
- `step_done_i`  in  1  core finished a timestep; `spk_out_i` is valid in the same cycle.
- `spk_out_i`  in  NEURONS  output spikes.
- `irq_o`  out  1  run-done interrupt, level.

## Operation
Register offsets (`adr[15:0]`):
- 0x0000 CTRL: bit0 start (write 1 to trigger, reads 0), bit1 irq_en (RW), bit2 abort (write 1 to trigger, reads 0).
- 0x0004 STATUS: bit0 busy (RO), bit1 done (write 1 to clear).
- 0x0008 TIMESTEPS: [15:0], RW, byte lanes honored.
- 0x000C STEP_COUNT: [15:0], RO.
- 0x0010 SPK_IN: [INPUTS-1:0], RW, drives `spk_in_o` directly, byte lanes honored.
- 0x0014 SPK_OUT: last latched `spk_out_i`, RO.
- 0x0018 SPK_ANY: sticky OR of `spk_out_i` across the run, RO.
- 0x1000–0x1FFC WEIGHT window: write only, reads return 0.
- Any other hit offset: acked; reads return 0 and writes are ignored.
- A miss is never acked.

Bus FSM (B_IDLE, B_WGT, B_ACK):
- B_IDLE → B_ACK on `cyc & stb & hit & !ack` for any access except a full-word weight write.
- B_IDLE → B_WGT on a weight write with `sel == 4'hF`. A weight write with a partial `sel` is acked and dropped.
- B_WGT: hold `w_wr_o` high with address and data stable; on `w_ready_i` go to B_ACK. There is no timeout.
- B_ACK: `ack_o` high for 1 cycle, register write commits, then return to B_IDLE.

Run FSM (R_IDLE, R_STEP, R_WAIT):
- Start accepted only in R_IDLE. It clears STEP_COUNT, SPK_ANY and done.
  - TIMESTEPS == 0: done is set immediately and the FSM stays in R_IDLE.
  - Otherwise go to R_STEP.
- Start while busy is ignored.
- R_STEP: `step_o` = 1 for one cycle, then go to R_WAIT.
- R_WAIT, on `step_done_i`:
  - Latch SPK_OUT, OR the sample into SPK_ANY, increment STEP_COUNT.
  - If the new count equals TIMESTEPS, set done and go to R_IDLE; otherwise go to R_STEP.
- `step_done_i` outside R_WAIT is ignored.
- Abort: from any state go to R_IDLE; done is not set; counters hold their values. Start and abort in the same write: abort wins.
- busy = (state != R_IDLE).
- `irq_o` = done & irq_en.
- Done set and done-W1C in the same cycle: set wins.
- Weight writes are accepted while busy; the core arbitrates them through `w_ready_i`.

## Timing
- Register access: stb sampled at edge N, `ack_o` high during cycle N+1, read data with ack. One wait state.
- Weight write: ack in the cycle after the `w_ready_i` sample. Minimum 2 wait states.
- CTRL start commits at the ack edge. `step_o` is high in the cycle after that edge.
- Per step: minimum 2 cycles, `step_o` → R_WAIT → `step_done_i`.
- Done, and `irq_o` when enabled, rise at the edge that samples the final `step_done_i`.
- Reset values:
  - Outputs: `ack_o`, `dat_o`, `w_wr_o`, `w_addr_o`, `w_data_o`, `spk_in_o`, `step_o`, `irq_o` all 0.
  - Registers: all 0.
  - FSMs: B_IDLE and R_IDLE.
- Reset mid-transaction drops the pending ack and any weight request.

## Structure
- Package `snn_pkg`: register offsets, WEIGHT window bounds, bus and run state enums, CTRL/STATUS bit indices.
- Sub-module `snn_run_ctrl`: holds the run FSM, STEP_COUNT, SPK_OUT and SPK_ANY. Inputs: start and abort pulses, TIMESTEPS. Output: a done-set pulse.
- The top level holds the bus FSM, decode and registers.

## Test plan
- Write TIMESTEPS = 3, then CTRL = 0x3 → exactly 3 `step_o` pulses, each answered by `step_done_i` with `spk_out_i` = 0x1, 0x4, 0x0 → SPK_OUT = 0x0, SPK_ANY = 0x5, STEP_COUNT = 3, done = 1, `irq_o` = 1. W1C STATUS = 0x2 → `irq_o` = 0.
- Write weight at 0x3000_1008 with data 0xDEADBEEF, hold `w_ready_i` low for 5 cycles → `w_wr_o` high with addr 2 throughout; ack 1 cycle after ready.
- TIMESTEPS = 0, start → done set with no `step_o`; start issued while busy → ignored, STEP_COUNT unchanged.
- Abort during R_WAIT after step 1 of 4 → busy = 0, done = 0, STEP_COUNT = 1; a late `step_done_i` is ignored.
- Read 0x3000_0040 → ack with data 0. Access 0x3001_0000 → no ack. Partial-`sel` weight write → acked, `w_wr_o` never asserted.
- Assert `wb_rst_i` while in B_WGT with a run busy → all outputs 0 the next cycle; the next register read returns reset values.
